game_controller: RTL

GAME_CONTROLLER -- requirements
Module: game_controller

---
 rtl/game_pkg.sv | 31 +++
 rtl/game_controller_if.sv | 25 ++
 rtl/frame_timer.sv | 28 ++
 rtl/game_controller.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the frogger-style game controller: FSM state
// encoding, default game parameters and level-to-speed-tier mapping.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } state_t;

  localparam int DEF_LIVES      = 3;
  localparam int DEF_HIT_FRAMES = 30;
  localparam int DEF_WIN_FRAMES = 20;
  localparam int DEF_GOAL_ROW   = 0;
  localparam int DEF_MAX_LEVEL  = 99;

  // First level of each faster car-speed tier
  localparam logic [6:0] TIER1_LEVEL = 7'd10;
  localparam logic [6:0] TIER2_LEVEL = 7'd30;
  localparam logic [6:0] TIER3_LEVEL = 7'd60;

  function automatic logic [1:0] speed_tier(input logic [6:0] level);
    if (level >= TIER3_LEVEL)      speed_tier = 2'd3;
    else if (level >= TIER2_LEVEL) speed_tier = 2'd2;
    else if (level >= TIER1_LEVEL) speed_tier = 2'd1;
    else                           speed_tier = 2'd0;
  endfunction

endpackage

// File: rtl/game_controller_if.sv
// Signal bundle between the renderer/input side and the game controller.
interface game_controller_if;
  logic       i_Frame_Start;
  logic       i_Collision;
  logic [3:0] i_Player_Y;
  logic       i_Start;
  logic       o_Player_Reset;
  logic [6:0] o_Level;
  logic [1:0] o_Lives;
  logic [2:0] o_State;
  logic       o_Freeze;
  logic [1:0] o_Speed_Tier;

  // Renderer / board side: drives game events, consumes game status
  modport master (
    output i_Frame_Start, i_Collision, i_Player_Y, i_Start,
    input  o_Player_Reset, o_Level, o_Lives, o_State, o_Freeze, o_Speed_Tier
  );

  // Controller side
  modport slave (
    input  i_Frame_Start, i_Collision, i_Player_Y, i_Start,
    output o_Player_Reset, o_Level, o_Lives, o_State, o_Freeze, o_Speed_Tier
  );
endinterface

// File: rtl/frame_timer.sv
// 6-bit frame-counting timer: load a duration, count down on each frame
// pulse, and flag expiry on the frame pulse that brings it to zero.
module frame_timer (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic       load,
  input  logic [5:0] load_val,
  input  logic       frame_tick,
  output logic       expire,
  output logic [5:0] count
);

  // A load wins over a coincident frame pulse, so the frame that starts
  // a freeze is not counted as part of it.
  assign expire = frame_tick && !load && (count == 6'd1);

  // Countdown register; parks at zero once expired
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      count <= 6'd0;
    end else if (load) begin
      count <= load_val;
    end else if (frame_tick && (count != 6'd0)) begin
      count <= count - 6'd1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game flow controller: start/play/hit/win/game-over sequencing, lives and
// level bookkeeping, freeze control and car speed tier selection.
module game_controller
  import game_pkg::*;
#(
  parameter int LIVES      = DEF_LIVES,
  parameter int HIT_FRAMES = DEF_HIT_FRAMES,
  parameter int WIN_FRAMES = DEF_WIN_FRAMES,
  parameter int GOAL_ROW   = DEF_GOAL_ROW,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL
) (
  input  logic               i_Clk,
  input  logic               i_Reset_n,
  game_controller_if.slave   bus
);

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [5:0] HIT_LOAD   = 6'(HIT_FRAMES);
  localparam logic [5:0] WIN_LOAD   = 6'(WIN_FRAMES);
  localparam logic [3:0] GOAL_Y     = 4'(GOAL_ROW);
  localparam logic [6:0] LEVEL_MAX  = 7'(MAX_LEVEL);

  state_t     state;
  logic [6:0] level;
  logic [1:0] lives;
  logic       freeze;
  logic       player_reset;
  logic [1:0] tier;
  logic       start_prev;
  logic       sticky_hit;
  logic       start_edge;
  logic       hit_now;
  logic       at_goal;
  logic       timer_load;
  logic [5:0] timer_val;
  logic       timer_expire;
  logic [5:0] timer_count;

  function automatic logic [1:0] lives_dec_sat(input logic [1:0] l);
    lives_dec_sat = (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

  function automatic logic [6:0] level_next(input logic [6:0] l);
    level_next = (l >= LEVEL_MAX) ? 7'd0 : l + 7'd1;
  endfunction

  assign start_edge = bus.i_Start && !start_prev;
  // A collision on the frame pulse itself still belongs to the ending frame
  assign hit_now    = sticky_hit || bus.i_Collision;
  assign at_goal    = (bus.i_Player_Y == GOAL_Y);

  // Freeze timer is armed on the frame pulse that leaves PLAY
  assign timer_load = (state == ST_PLAY) && bus.i_Frame_Start && (hit_now || at_goal);
  assign timer_val  = hit_now ? HIT_LOAD : WIN_LOAD;

  frame_timer u_frame_timer (
    .i_Clk      (i_Clk),
    .i_Reset_n  (i_Reset_n),
    .load       (timer_load),
    .load_val   (timer_val),
    .frame_tick (bus.i_Frame_Start),
    .expire     (timer_expire),
    .count      (timer_count)
  );

  // Start switch history for edge detection
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) start_prev <= 1'b0;
    else            start_prev <= bus.i_Start;
  end

  // Per-frame sticky collision flag, only armed while playing
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n)                                   sticky_hit <= 1'b0;
    else if (bus.i_Frame_Start)                       sticky_hit <= 1'b0;
    else if (state == ST_PLAY && bus.i_Collision)     sticky_hit <= 1'b1;
  end

  // Game FSM with registered level, lives, freeze and player-reset pulse
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= ST_IDLE;
      level        <= 7'd0;
      lives        <= LIVES_INIT;
      freeze       <= 1'b1;
      player_reset <= 1'b0;
    end else begin
      player_reset <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (start_edge) begin
            state        <= ST_PLAY;
            level        <= 7'd0;
            lives        <= LIVES_INIT;
            freeze       <= 1'b0;
            player_reset <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (bus.i_Frame_Start) begin
            if (hit_now) begin
              state  <= ST_HIT;
              lives  <= lives_dec_sat(lives);
              freeze <= 1'b1;
            end else if (at_goal) begin
              state  <= ST_WIN;
              level  <= level_next(level);
              freeze <= 1'b1;
            end
          end
        end
        ST_HIT: begin
          if (timer_expire) begin
            if (lives == 2'd0) begin
              state <= ST_OVER;
            end else begin
              state        <= ST_PLAY;
              freeze       <= 1'b0;
              player_reset <= 1'b1;
            end
          end
        end
        ST_WIN: begin
          if (timer_expire) begin
            state        <= ST_PLAY;
            freeze       <= 1'b0;
            player_reset <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          freeze <= 1'b1;
        end
      endcase
    end
  end

  // Speed tier follows the registered level one cycle later
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) tier <= 2'd0;
    else            tier <= speed_tier(level);
  end

  assign bus.o_State        = state;
  assign bus.o_Level        = level;
  assign bus.o_Lives        = lives;
  assign bus.o_Freeze       = freeze;
  assign bus.o_Player_Reset = player_reset;
  assign bus.o_Speed_Tier   = tier;

endmodule
